// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and constants for the iterative multiply/divide unit.
package mult_div_unit_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam int          ITERATIONS   = 32;
  localparam logic [31:0] DIV_ZERO_QUO = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic op_is_signed(input logic [1:0] op);
    return !op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/mult_div_unit_sign_fix.sv
// Conditional two's-complement negator; used for operand magnitudes and result signs.
module sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic         neg,
  output logic [W-1:0] y
);

  assign y = neg ? (~a + W'(1)) : a;

endmodule

// File: rtl/mult_div_unit.sv
// 32-cycle shift-add multiplier / restoring divider with HI/LO result registers.
// start is a one-cycle request honoured only in IDLE; busy covers RUN and DONE; done pulses in DONE.
module mult_div_unit
  import mult_div_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operandA,
  input  logic [31:0] operandB,
  input  logic        hiWrite,
  input  logic        loWrite,
  input  logic [31:0] writeData,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output state_t      dbg_state
);

  state_t      state, state_next;
  logic [5:0]  cnt;
  logic        is_div_q, neg_q_q, neg_r_q, dz_q;
  logic [31:0] opnd_q;
  logic [63:0] acc_q, acc_step;
  logic [32:0] sum, sh;
  logic [31:0] diff;
  logic        idle, last, sgn_in;
  logic [31:0] fa_in, fb_in, fa_out, fb_out;
  logic        fa_neg, fb_neg;
  logic [63:0] fp_out;
  logic [31:0] res_hi, res_lo;

  assign idle      = (state == ST_IDLE);
  assign last      = (cnt == 6'd1);
  assign sgn_in    = op_is_signed(op);
  assign busy      = !idle;
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

  // The 32-bit negators make operand magnitudes in IDLE and fix quotient/remainder signs in RUN.
  assign fa_in  = idle ? operandA : acc_step[31:0];
  assign fa_neg = idle ? (sgn_in & operandA[31]) : neg_q_q;
  assign fb_in  = idle ? operandB : acc_step[63:32];
  assign fb_neg = idle ? (sgn_in & operandB[31]) : neg_r_q;

  sign_fix #(.W(32)) u_fix_a (.a(fa_in),    .neg(fa_neg),  .y(fa_out));
  sign_fix #(.W(32)) u_fix_b (.a(fb_in),    .neg(fb_neg),  .y(fb_out));
  sign_fix #(.W(64)) u_fix_p (.a(acc_step), .neg(neg_q_q), .y(fp_out));

  // Divide-by-zero leaves hi = |A| after the loop; the remainder sign fix restores A itself.
  assign res_hi = is_div_q ? fb_out : fp_out[63:32];
  assign res_lo = is_div_q ? (dz_q ? DIV_ZERO_QUO : fa_out) : fp_out[31:0];

  // acc holds {partial product} for multiply and {remainder, quotient} for divide.
  always_comb begin
    sum  = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
    sh   = acc_q[63:31];
    diff = sh[31:0] - opnd_q;
    if (is_div_q) begin
      if (sh >= {1'b0, opnd_q}) acc_step = {diff, acc_q[30:0], 1'b1};
      else                      acc_step = {sh[31:0], acc_q[30:0], 1'b0};
    end else if (acc_q[0]) begin
      acc_step = {sum, acc_q[31:1]};
    end else begin
      acc_step = {1'b0, acc_q[63:1]};
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last)  state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt      <= 6'd0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      opnd_q   <= 32'd0;
      acc_q    <= 64'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (hiWrite) hi <= writeData;
          if (loWrite) lo <= writeData;
          if (start) begin
            cnt      <= 6'(ITERATIONS);
            is_div_q <= op_is_div(op);
            neg_q_q  <= sgn_in & (operandA[31] ^ operandB[31]);
            neg_r_q  <= sgn_in & operandA[31];
            dz_q     <= op_is_div(op) && (operandB == 32'd0);
            opnd_q   <= op_is_div(op) ? fb_out : fa_out;
            acc_q    <= {32'd0, op_is_div(op) ? fa_out : fb_out};
          end
        end
        ST_RUN: begin
          acc_q <= acc_step;
          cnt   <= cnt - 6'd1;
          if (last) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases with literal results plus randomized traffic
// checked every cycle against an arithmetic model of HI/LO and the busy/done timeline.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] operandA = 32'd0;
  logic [31:0] operandB = 32'd0;
  logic        hiWrite = 1'b0;
  logic        loWrite = 1'b0;
  logic [31:0] writeData = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;
  state_t      dbg_state;

  int tests = 0;
  int fails = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, required finish before time limit");
    $fatal(1);
  end

  mult_div_unit dut (
    .clock(clock), .reset(reset), .start(start), .op(op),
    .operandA(operandA), .operandB(operandB),
    .hiWrite(hiWrite), .loWrite(loWrite), .writeData(writeData),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbg_state(dbg_state)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [31:0] sa, sb, sq, sr;
    logic [63:0] r;
    sa = a;
    sb = b;
    case (o)
      OP_MULT:  r = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      OP_MULTU: r = {32'd0, a} * {32'd0, b};
      OP_DIV: begin
        if (b == 32'd0) r = {a, 32'hFFFFFFFF};
        else if (a == 32'h80000000 && b == 32'hFFFFFFFF) r = {32'd0, 32'h80000000};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          r = {sr, sq};
        end
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFFFFFF};
        else r = {a % b, a / b};
      end
    endcase
    return r;
  endfunction

  // m_cnt: cycles of busy left (33 after a start: 32 RUN + 1 DONE), 0 when idle.
  int          m_cnt = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [63:0] m_pend = 64'd0;
  int          cyc = 0;
  bit          started = 1'b0;

  logic [63:0] exp_q[$];
  int          lat_q[$];

  always @(posedge clock) begin
    started = 1'b1;
    if (reset) begin
      m_cnt = 0;
      m_hi  = 32'd0;
      m_lo  = 32'd0;
      exp_q.delete();
      lat_q.delete();
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 1) {m_hi, m_lo} = m_pend;
    end else begin
      if (hiWrite) m_hi = writeData;
      if (loWrite) m_lo = writeData;
      if (start) begin
        m_pend = ref_result(op, operandA, operandB);
        m_cnt  = 33;
        exp_q.push_back(m_pend);
        lat_q.push_back(cyc);
      end
    end
    cyc++;
  end

  // ---------------- per-cycle compare + scoreboard ----------------
  logic [63:0] r_exp;
  state_t      s_exp;
  int          lat;

  always @(negedge clock) begin
    if (started) begin
      s_exp = (m_cnt == 0) ? ST_IDLE : ((m_cnt == 1) ? ST_DONE : ST_RUN);
      check("busy",  64'(busy), 64'(m_cnt > 0));
      check("done",  64'(done), 64'(m_cnt == 1));
      check("hi",    64'(hi), 64'(m_hi));
      check("lo",    64'(lo), 64'(m_lo));
      check("state", 64'(dbg_state), 64'(s_exp));
      if (done) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL done_unexpected: got done=1 expected no pending operation");
        end else begin
          r_exp = exp_q.pop_front();
          lat   = cyc - lat_q.pop_front() + 1;
          check("result", {hi, lo}, r_exp);
          check("latency", 64'(lat), 64'd34);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o;
    operandA = a;
    operandB = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    op = 2'($urandom);
    operandA = $urandom;
    operandB = $urandom;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 60) begin
      @(negedge clock);
      n++;
      if (done) return;
    end
    n = -1;
    tests++;
    fails++;
    $display("FAIL wait_done: got no done within 60 cycles, required a done pulse");
  endtask

  task automatic run_directed(input string name, input logic [1:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int n;
    start_op(o, a, b);
    wait_done(n);
    if (n > 0) begin
      check({name, "_latency"}, 64'(n + 1), 64'd34);
      check({name, "_hilo"}, {hi, lo}, {eh, el});
    end
    tick();
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (done) cnt++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int nd;
    int gap;
    logic [1:0]  o;
    logic [31:0] a, b;

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    tick();

    run_directed("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    run_directed("mult_m3x7", OP_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB);
    run_directed("div_m7d2",  OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_directed("divu_dz",   OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF);
    run_directed("div_ovf",   OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000);
    run_directed("div_dz_neg", OP_DIV,  32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF);

    // Second start and MTHI in RUN cycle 10 must both be ignored.
    start_op(OP_DIVU, 32'd100, 32'd7);
    repeat (9) tick();
    start = 1'b1;
    op = OP_MULT;
    operandA = $urandom;
    operandB = $urandom;
    hiWrite = 1'b1;
    writeData = 32'hDEADBEEF;
    tick();
    start = 1'b0;
    hiWrite = 1'b0;
    wait_done(n);
    if (n > 0) check("busy_ignore_hilo", {hi, lo}, {32'd2, 32'd14});
    count_dones(40, nd);
    check("busy_ignore_single_done", 64'(nd), 64'd0);
    tick();

    // MTLO in IDLE leaves hi untouched.
    loWrite = 1'b1;
    writeData = 32'hA5A5A5A5;
    tick();
    loWrite = 1'b0;
    @(negedge clock);
    check("mtlo", {hi, lo}, {32'd2, 32'hA5A5A5A5});
    tick();

    // Reset during RUN cycle 20 aborts with no done.
    start_op(OP_MULTU, $urandom, $urandom);
    repeat (19) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    count_dones(40, nd);
    check("abort_no_done", 64'(nd), 64'd0);
    tick();

    // MTHI together with start: write lands, then DONE overwrites it.
    hiWrite = 1'b1;
    writeData = 32'h12345678;
    start_op(OP_MULTU, 32'd3, 32'd5);
    hiWrite = 1'b0;
    @(negedge clock);
    check("mthi_with_start", 64'(hi), 64'h12345678);
    wait_done(n);
    if (n > 0) check("mthi_overwritten", {hi, lo}, {32'd0, 32'd15});
    tick();

    // Randomized traffic, checked every cycle by the model.
    for (int t = 0; t < 40; t++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        hiWrite = ($urandom_range(0, 3) == 0);
        loWrite = ($urandom_range(0, 3) == 0);
        writeData = $urandom;
        tick();
      end
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = $urandom_range(1, 15);
        3: a = $urandom_range(0, 1000);
        4: b = 32'hFFFFFFFF;
        default: ;
      endcase
      hiWrite = ($urandom_range(0, 3) == 0);
      loWrite = ($urandom_range(0, 3) == 0);
      writeData = $urandom;
      start_op(o, a, b);
      for (int i = 0; i < 33; i++) begin
        start = 1'($urandom_range(0, 1));
        hiWrite = 1'($urandom_range(0, 1));
        loWrite = 1'($urandom_range(0, 1));
        writeData = $urandom;
        operandA = $urandom;
        operandB = $urandom;
        tick();
      end
      start = 1'b0;
      hiWrite = 1'b0;
      loWrite = 1'b0;
    end

    repeat (3) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
